// File: rtl/seq_enc4_verilog.sv
// seq_enc4_verilog: synchronizes four push switches, captures a 2-bit code on a rising edge and holds POUT for HOLD_LEN cycles
// Ports: CLK clock, R sync active-high reset, PSW0..PSW3 async switches (PSW0 highest priority),
//   RDY_IN downstream ready, {Q1,Q0} captured code, POUT_ONE capture strobe, POUT hold window,
//   RDY high in IDLE, ERR sequence-error strobe (only when SEQ_ENC4_SEQCHK_EN is defined).
// Optional feature macro: SEQ_ENC4_SEQCHK_EN adds the ERR port and expected-code sequence checking.
module seq_enc4_verilog #(
  parameter logic [23:0] HOLD_LEN = 24'd12000000
) (
  input  logic CLK,
  input  logic R,
  input  logic PSW0,
  input  logic PSW1,
  input  logic PSW2,
  input  logic PSW3,
  input  logic RDY_IN,
  output logic Q0,
  output logic Q1,
  output logic POUT_ONE,
  output logic POUT,
  output logic RDY
`ifdef SEQ_ENC4_SEQCHK_EN
  ,
  output logic ERR
`endif
);
  // Timer counts down to zero, so the load value is one less than the window; 0 behaves like 1.
  localparam logic [23:0] LOAD = (HOLD_LEN == 24'd0) ? 24'd0 : HOLD_LEN - 24'd1;
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;
  state_t state, state_n;
  logic [3:0] psw, s1, s2, s3, rise;
  logic [23:0] timer, timer_n;
  logic [1:0] q, q_n, code;
  logic pout, pout_n, pout_one, cap;
  assign psw = {PSW3, PSW2, PSW1, PSW0};
  assign rise = s2 & ~s3;
  assign code = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
  assign cap = (state == IDLE) && RDY_IN && (|rise);
  assign {Q1, Q0} = q;
  assign POUT_ONE = pout_one;
  assign POUT = pout;
  assign RDY = state == IDLE;
  always_comb begin
    state_n = state;
    timer_n = timer;
    q_n = q;
    pout_n = pout;
    if (cap) begin
      state_n = HOLD;
      timer_n = LOAD;
      q_n = code;
      pout_n = 1'b1;
    end else if (state == HOLD) begin
      state_n = (timer == 24'd0) ? ((|s2) ? WAIT_REL : IDLE) : HOLD;
      pout_n = timer != 24'd0;
      timer_n = (timer == 24'd0) ? timer : timer - 24'd1;
    end else if (state == WAIT_REL) begin
      state_n = (|s2) ? WAIT_REL : IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (R) begin
      state <= IDLE;
      timer <= '0;
      q <= '0;
      pout <= 1'b0;
      pout_one <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      q <= q_n;
      pout <= pout_n;
      pout_one <= cap;
      s1 <= psw;
      s2 <= s1;
      s3 <= s2;
    end
  end
`ifdef SEQ_ENC4_SEQCHK_EN
  logic [1:0] exp_code;
  logic err;
  assign ERR = err;
  always_ff @(posedge CLK) begin
    if (R) begin
      exp_code <= '0;
      err <= 1'b0;
    end else begin
      exp_code <= cap ? code + 2'd1 : exp_code;
      err <= cap && (code != exp_code);
    end
  end
`endif
endmodule

// File: tb/tb_seq_enc4_verilog.sv
// tb_seq_enc4_verilog: directed and randomized checks of seq_enc4_verilog against a cycle-count reference model
module tb_seq_enc4_verilog;
  localparam int HL = 8;
  logic CLK = 1'b0;
  logic R, PSW0, PSW1, PSW2, PSW3, RDY_IN;
  logic Q0, Q1, POUT_ONE, POUT, RDY;
`ifdef SEQ_ENC4_SEQCHK_EN
  logic ERR;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] m_q = '0;
  logic m_po1 = 1'b0, m_pout = 1'b0, m_err = 1'b0;
  int m_mode = 0, m_left = 0, m_exp = 0;
  logic [3:0] ph[$] = '{4'd0, 4'd0, 4'd0};
  logic [4:0] dv, mv;
  assign dv = {Q1, Q0, POUT_ONE, POUT, RDY};
  assign mv = {m_q, m_po1, m_pout, m_mode == 0};
  always #5 CLK = ~CLK;
  seq_enc4_verilog #(.HOLD_LEN(24'd8)) dut (
    .CLK(CLK), .R(R), .PSW0(PSW0), .PSW1(PSW1), .PSW2(PSW2), .PSW3(PSW3), .RDY_IN(RDY_IN),
    .Q0(Q0), .Q1(Q1), .POUT_ONE(POUT_ONE), .POUT(POUT), .RDY(RDY)
`ifdef SEQ_ENC4_SEQCHK_EN
    , .ERR(ERR)
`endif
  );
  // ph holds the switch values sampled at the three previous edges, oldest first.
  task automatic tick(input logic r, input logic rd, input logic [3:0] p);
    logic [3:0] rise;
    int c;
    R = r;
    RDY_IN = rd;
    {PSW3, PSW2, PSW1, PSW0} = p;
    @(posedge CLK);
    if (r) begin
      m_q = '0; m_po1 = 0; m_pout = 0; m_err = 0; m_mode = 0; m_left = 0; m_exp = 0;
      ph = '{4'd0, 4'd0, 4'd0};
    end else begin
      rise = ph[1] & ~ph[0];
      m_po1 = 0;
      m_err = 0;
      if (m_mode == 0) begin
        if (rd && rise != 4'd0) begin
          c = 0;
          for (int i = 3; i >= 0; i--) if (rise[i]) c = i;
          m_q = c[1:0];
          m_err = (c != m_exp);
          m_exp = (c + 1) % 4;
          m_po1 = 1;
          m_pout = 1;
          m_left = HL;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_pout = 0;
          m_mode = (ph[1] != 4'd0) ? 2 : 0;
        end
      end else if (ph[1] == 4'd0) m_mode = 0;
      void'(ph.pop_front());
      ph.push_back(p);
    end
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 4'd0);
      n_chk++;
      if (dv !== 5'b00001) begin n_fail++; $display("FAIL reset: {Q1,Q0,POUT_ONE,POUT,RDY}=%b expected 00001", dv); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 4'd0);
      n_chk++;
      if (dv !== mv) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", dv, mv); end
    end
  endtask
  task automatic test_capture();
    int po1 = 0, pw = 0;
    for (int i = 0; i < 14; i++) begin
      tick(0, 1, i < 3 ? 4'b0100 : 4'd0);
      po1 += int'(POUT_ONE);
      pw += int'(POUT);
      n_chk++;
      if (dv !== mv) begin n_fail++; $display("FAIL capture cyc %0d: got %b expected %b", i, dv, mv); end
      if (i == 2) begin
        n_chk++;
        if (dv !== 5'b10110) begin n_fail++; $display("FAIL capture_latency: got %b expected 10110", dv); end
      end
    end
    n_chk++;
    if (po1 != 1 || pw != HL) begin n_fail++; $display("FAIL capture_width: POUT_ONE cycles %0d POUT cycles %0d expected 1 and %0d", po1, pw, HL); end
  endtask
  task automatic test_simultaneous();
    int po1 = 0;
    for (int i = 0; i < 16; i++) begin
      tick(0, 1, i < 2 ? 4'b1010 : (i >= 4 && i < 6) ? 4'b0001 : 4'd0);
      po1 += int'(POUT_ONE);
      n_chk++;
      if (dv !== mv) begin n_fail++; $display("FAIL simultaneous cyc %0d: got %b expected %b", i, dv, mv); end
    end
    n_chk++;
    if ({Q1, Q0} !== 2'b01 || po1 != 1) begin n_fail++; $display("FAIL priority: code %b captures %0d expected 01 and 1", {Q1, Q0}, po1); end
  endtask
  task automatic test_wait_rel();
    int po1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, i < 14 ? 4'b0001 : 4'd0);
      po1 += int'(POUT_ONE);
      n_chk++;
      if (dv !== mv) begin n_fail++; $display("FAIL wait_rel cyc %0d: got %b expected %b", i, dv, mv); end
      if (i == 12) begin
        n_chk++;
        if (RDY !== 1'b0 || POUT !== 1'b0) begin n_fail++; $display("FAIL wait_rel_state: RDY=%b POUT=%b expected 0 0", RDY, POUT); end
      end
    end
    n_chk++;
    if (RDY !== 1'b1 || po1 != 1) begin n_fail++; $display("FAIL wait_rel_exit: RDY=%b captures %0d expected 1 and 1", RDY, po1); end
  endtask
  task automatic test_rdy_in();
    int po1 = 0;
    for (int i = 0; i < 14; i++) begin
      tick(0, i >= 4, i < 10 ? 4'b1000 : 4'd0);
      po1 += int'(POUT_ONE);
      n_chk++;
      if (dv !== mv) begin n_fail++; $display("FAIL rdy_in cyc %0d: got %b expected %b", i, dv, mv); end
    end
    n_chk++;
    if (po1 != 0 || {Q1, Q0} !== 2'b00) begin n_fail++; $display("FAIL rdy_in_drop: captures %0d code %b expected 0 and 00", po1, {Q1, Q0}); end
  endtask
  task automatic test_reset_in_hold();
    for (int i = 0; i < 10; i++) begin
      tick(i == 6, 1, i < 2 ? 4'b0010 : 4'd0);
      n_chk++;
      if (dv !== mv) begin n_fail++; $display("FAIL reset_in_hold cyc %0d: got %b expected %b", i, dv, mv); end
      if (i == 6) begin
        n_chk++;
        if (dv !== 5'b00001) begin n_fail++; $display("FAIL reset_override: got %b expected 00001", dv); end
      end
    end
  endtask
`ifdef SEQ_ENC4_SEQCHK_EN
  task automatic test_seqchk();
    int codes[7] = '{0, 1, 2, 3, 0, 2, 3};
    int errs = 0, err_at = -1;
    logic [3:0] p;
    tick(1, 1, 4'd0);
    for (int k = 0; k < 7; k++) begin
      p = 4'b0001 << codes[k];
      for (int j = 0; j < 14; j++) begin
        tick(0, 1, j < 2 ? p : 4'd0);
        if (ERR === 1'b1) begin errs++; err_at = k; end
        n_chk++;
        if (dv !== mv || ERR !== m_err) begin n_fail++; $display("FAIL seqchk cap %0d cyc %0d: got %b/%b expected %b/%b", k, j, dv, ERR, mv, m_err); end
      end
    end
    n_chk++;
    if (errs != 1 || err_at != 5) begin n_fail++; $display("FAIL seqchk_err: pulses %0d at capture %0d expected 1 at 5", errs, err_at); end
  endtask
`endif
  task automatic test_random();
    logic [3:0] p = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) p = 4'($urandom);
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, p);
      n_chk++;
      if (dv !== mv) begin n_fail++; $display("FAIL random cyc %0d: got %b expected %b", i, dv, mv); end
`ifdef SEQ_ENC4_SEQCHK_EN
      n_chk++;
      if (ERR !== m_err) begin n_fail++; $display("FAIL random_err cyc %0d: ERR=%b expected %b", i, ERR, m_err); end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_capture();
    test_simultaneous();
    test_wait_rel();
    test_rdy_in();
    test_reset_in_hold();
`ifdef SEQ_ENC4_SEQCHK_EN
    test_seqchk();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_enc4_verilog.md
SEQ_ENC4_VERILOG -- requirements
Module: seq_enc4_verilog

Interface
REQ-001 Parameter HOLD_LEN, default 24'd12000000: POUT high time in CLK cycles; a value of 0 is treated as 1.
REQ-002 CLK  input  1  single system clock; all state updates on the rising edge.
REQ-003 R  input  1  reset, synchronous and active-high.
REQ-004 PSW0..PSW3  input  1 each  asynchronous push switches, active-high, one per code 0..3.
REQ-005 RDY_IN  input  1  downstream ready; a capture is allowed only while RDY_IN=1.
REQ-006 Q0, Q1  output  1 each  captured 2-bit code, {Q1,Q0}, registered.
REQ-007 POUT_ONE  output  1  one-cycle strobe marking a new capture.
REQ-008 POUT  output  1  high for the HOLD_LEN-cycle hold window following a capture.
REQ-009 RDY  output  1  high when the block is in IDLE.
REQ-010 ERR  output  1  sequence-error strobe; the port exists only with SEQ_ENC4_SEQCHK_EN.

Function
REQ-011 Each PSWn SHALL pass through a 2-FF synchronizer, then a rising-edge detector built from a third register.
REQ-012 The FSM SHALL have three states: IDLE, HOLD and WAIT_REL.
REQ-013 In IDLE with RDY_IN=1 and at least one detected rising edge, the FSM SHALL capture a code, go to HOLD, load the timer and pulse POUT_ONE.
REQ-014 Simultaneous edges SHALL resolve by priority to the lowest index: PSW0 > PSW1 > PSW2 > PSW3.
REQ-015 Latency: with PSWn first sampled high at edge k, {Q1,Q0}, POUT_ONE and POUT SHALL all update at edge k+2.
REQ-016 POUT_ONE SHALL be high for exactly one cycle per capture.
REQ-017 POUT SHALL stay high for exactly max(HOLD_LEN,1) cycles, using a 24-bit down-counter.
REQ-018 {Q1,Q0} SHALL hold the last captured code until the next capture and SHALL NOT be cleared when POUT falls.
REQ-019 Edges arriving in HOLD or WAIT_REL, or in IDLE with RDY_IN=0, SHALL be dropped, not queued.
REQ-020 At the end of HOLD the FSM SHALL go to WAIT_REL if any synchronized switch is high, otherwise to IDLE.
REQ-021 WAIT_REL SHALL return to IDLE on the first cycle in which all synchronized switches are low.
REQ-022 RDY SHALL be high exactly while the FSM is in IDLE, independent of RDY_IN.
REQ-023 A switch still held when the FSM re-enters IDLE SHALL NOT cause a capture; only a new rising edge does.

Reset
REQ-024 R=1 at a clock edge SHALL clear all of: Q0, Q1, POUT_ONE, POUT, ERR, timer, synchronizers and edge registers; the FSM SHALL go to IDLE and RDY SHALL be 1 at that edge.
REQ-025 Reset SHALL override every other event, including a capture in the same cycle and an active HOLD window.
REQ-026 The first capture after reset SHALL require a fresh rising edge.

Configuration
REQ-027 Macro SEQ_ENC4_SEQCHK_EN, when defined, SHALL add the ERR port and a 2-bit expected-code register that resets to 0.
REQ-028 With the macro defined, ERR SHALL pulse for one cycle, together with POUT_ONE, when the captured code differs from the expected code.
REQ-029 With the macro defined, the expected code SHALL be set to (captured code + 1) mod 4 on every capture, wrapping 3 to 0, so a single error resynchronizes.
REQ-030 Without the macro, the ERR port and all checking logic SHALL be absent, and every other behaviour SHALL be unchanged.

Verification (bench uses HOLD_LEN=8)
REQ-031 Reset, then PSW2 high at edge 10 with RDY_IN=1 -> at edge 12: Q1Q0=10, POUT_ONE high for 1 cycle, POUT high for 8 cycles, RDY=0.
REQ-032 PSW1 and PSW3 rise in the same cycle -> Q1Q0=01; a PSW0 edge during HOLD -> no capture, Q1Q0 stays 01.
REQ-033 PSW0 held across the end of HOLD -> FSM in WAIT_REL with RDY=0; release -> RDY=1 the following cycle; still no second capture.
REQ-034 RDY_IN=0 during a PSW3 edge -> no POUT_ONE; RDY_IN then set to 1 while PSW3 is still held -> still no capture.
REQ-035 R asserted at the 4th cycle of HOLD -> next edge: POUT=0, Q1Q0=00, RDY=1.
REQ-036 With SEQ_ENC4_SEQCHK_EN, captures 0,1,2,3,0 -> ERR never set; then captures 2,3 -> ERR pulses on code 2 only.
